lane_scroller: RTL and testbench

- One traffic lane of the Crossy-Road playfield.
- Downstream consumer of the rate-divider Enable tick: each tick shifts the lane's car bitmap by one cell and spawns new cars from an LFSR.
- Checks the frog position against the lane and latches a collision.
- LaneCells feeds the renderer; Hit feeds the game-control FSM.

---
 rtl/lane_scroller.sv | 144 ++++++++++++++
 tb/tb_lane_scroller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lane_scroller.sv
// lane_scroller: one playfield lane; shifts a car bitmap on each Enable tick, spawns cars from an LFSR
// and latches a frog collision. Define LANE_WRAP_EN to recirculate exiting cars to the entry edge.
module lane_scroller #(
  parameter int          LANE_WIDTH    = 16,
  parameter int          COL_W         = 4,
  parameter int          DIRECTION     = 0,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int          SPAWN_GAP_MIN = 3
) (
  input  logic                  ClockIn,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  Run,
  input  logic                  FrogInLane,
  input  logic [COL_W-1:0]      FrogCol,
  output logic [LANE_WIDTH-1:0] LaneCells,
  output logic                  LaneMoved,
  output logic                  Hit
);

  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [3:0]  GAP_MIN   = 4'(SPAWN_GAP_MIN);
  localparam logic [3:0]  GAP_MAX   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HIT  = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [LANE_WIDTH-1:0] cells_q, cells_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [3:0]            gap_q, gap_d;
  logic                  moved_q, moved_d;
  logic                  hit_q, hit_d;

  logic [31:0]           frog_col_s;
  logic                  frog_cell_s;
  logic                  coll_s;
  logic                  tick_s;
  logic                  spawn_s;
  logic                  entry_s;
  logic [LANE_WIDTH-1:0] shifted_s;

  // Galois right-shift step of the spawn LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  function automatic logic [3:0] gap_inc(input logic [3:0] cur);
    return (cur == GAP_MAX) ? GAP_MAX : cur + 4'd1;
  endfunction

  // Cell under the frog; columns beyond the lane never match, so they read as empty.
  always_comb begin
    frog_col_s  = 32'(FrogCol);
    frog_cell_s = 1'b0;
    for (int i = 0; i < LANE_WIDTH; i++) begin
      frog_cell_s = (frog_col_s == 32'(i)) ? cells_q[i] : frog_cell_s;
    end
  end

  assign coll_s  = (state_q == ST_RUN) && FrogInLane && frog_cell_s;
  assign tick_s  = (state_q == ST_RUN) && Run && Enable && !coll_s;
  assign spawn_s = (lfsr_q[1:0] == 2'b00) && (gap_q >= GAP_MIN);

`ifdef LANE_WRAP_EN
  assign entry_s = spawn_s | ((DIRECTION == 0) ? cells_q[0] : cells_q[LANE_WIDTH-1]);
`else
  assign entry_s = spawn_s;
`endif

  generate
    if (DIRECTION == 0) begin : g_toward_zero
      assign shifted_s = {entry_s, cells_q[LANE_WIDTH-1:1]};
    end else begin : g_toward_top
      assign shifted_s = {cells_q[LANE_WIDTH-2:0], entry_s};
    end
  endgenerate

  // State and datapath registers; reset wins over everything, including HIT.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cells_q <= '0;
      lfsr_q  <= LFSR_INIT;
      gap_q   <= GAP_MIN;
      moved_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cells_q <= cells_d;
      lfsr_q  <= lfsr_d;
      gap_q   <= gap_d;
      moved_q <= moved_d;
      hit_q   <= hit_d;
    end
  end

  // Next-state logic; a collision outranks a Run drop in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = Run ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (coll_s) begin
          state_d = ST_HIT;
        end else if (!Run) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HIT:  state_d = ST_HIT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath updates: shift on a tick, otherwise latch a collision.
  always_comb begin
    cells_d = cells_q;
    lfsr_d  = lfsr_q;
    gap_d   = gap_q;
    moved_d = 1'b0;
    hit_d   = hit_q;
    if (tick_s) begin
      cells_d = shifted_s;
      lfsr_d  = lfsr_step(lfsr_q);
      gap_d   = spawn_s ? 4'd0 : gap_inc(gap_q);
      moved_d = 1'b1;
    end else if (coll_s) begin
      hit_d = 1'b1;
    end else begin
      hit_d = hit_q;
    end
  end

  assign LaneCells = cells_q;
  assign LaneMoved = moved_q;
  assign Hit       = hit_q;

endmodule

// File: tb/tb_lane_scroller.sv
// tb_lane_scroller: directed scoreboard bench over three lane_scroller configurations.
module tb_lane_scroller;

  typedef struct {
    int          inst;
    logic [15:0] cells;
    logic        moved;
    logic        hit;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_a, run_a, fin_a;
  logic [3:0]  fcol_a;
  logic        en_b, run_b, fin_b;
  logic [3:0]  fcol_b;
  logic        en_c, run_c, fin_c;
  logic [3:0]  fcol_c;
  logic [15:0] cells_a;
  logic [11:0] cells_b;
  logic [15:0] cells_c;
  logic        moved_a, moved_b, moved_c;
  logic        hit_a, hit_b, hit_c;

  lane_scroller #(.LANE_WIDTH(16), .COL_W(4), .DIRECTION(0), .SEED(16'h0004), .SPAWN_GAP_MIN(3)) u_a (
    .ClockIn(clk), .Reset(rst), .Enable(en_a), .Run(run_a), .FrogInLane(fin_a), .FrogCol(fcol_a),
    .LaneCells(cells_a), .LaneMoved(moved_a), .Hit(hit_a));

  lane_scroller #(.LANE_WIDTH(12), .COL_W(4), .DIRECTION(0), .SEED(16'h0004), .SPAWN_GAP_MIN(3)) u_b (
    .ClockIn(clk), .Reset(rst), .Enable(en_b), .Run(run_b), .FrogInLane(fin_b), .FrogCol(fcol_b),
    .LaneCells(cells_b), .LaneMoved(moved_b), .Hit(hit_b));

  lane_scroller #(.LANE_WIDTH(16), .COL_W(4), .DIRECTION(1), .SEED(16'hACE1), .SPAWN_GAP_MIN(15)) u_c (
    .ClockIn(clk), .Reset(rst), .Enable(en_c), .Run(run_c), .FrogInLane(fin_c), .FrogCol(fcol_c),
    .LaneCells(cells_c), .LaneMoved(moved_c), .Hit(hit_c));

  // Cycles with LaneMoved high on instance A, sampled mid-cycle.
  int moved_cnt_a = 0;
  always @(negedge clk) begin
    if (moved_a === 1'b1) moved_cnt_a++;
  end

  task automatic check_out();
    exp_t        x;
    logic [15:0] oc;
    logic        om, oh;
    x = sb.pop_front();
    case (x.inst)
      0:       begin oc = cells_a;          om = moved_a; oh = hit_a; end
      1:       begin oc = {4'h0, cells_b};  om = moved_b; oh = hit_b; end
      default: begin oc = cells_c;          om = moved_c; oh = hit_c; end
    endcase
    checks++;
    assert (oc === x.cells) else begin
      errors++;
      $error("FAIL %s cells: observed %h expected %h", x.tag, oc, x.cells);
    end
    checks++;
    assert (om === x.moved) else begin
      errors++;
      $error("FAIL %s moved: observed %b expected %b", x.tag, om, x.moved);
    end
    checks++;
    assert (oh === x.hit) else begin
      errors++;
      $error("FAIL %s hit: observed %b expected %b", x.tag, oh, x.hit);
    end
  endtask

  // Drive one cycle of stimulus on one instance, queue its expected outputs, then check after the edge.
  task automatic step(input int inst, input logic r, input logic e, input logic rn, input logic fi,
                      input logic [3:0] fc, input logic [15:0] x_cells, input logic x_moved,
                      input logic x_hit, input string tag);
    exp_t x;
    rst = r;
    case (inst)
      0:       begin en_a = e; run_a = rn; fin_a = fi; fcol_a = fc; end
      1:       begin en_b = e; run_b = rn; fin_b = fi; fcol_b = fc; end
      default: begin en_c = e; run_c = rn; fin_c = fi; fcol_c = fc; end
    endcase
    x.inst  = inst;
    x.cells = x_cells;
    x.moved = x_moved;
    x.hit   = x_hit;
    x.tag   = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] spawn_exp [5];
    logic [15:0] one;
    logic [15:0] wrap_exp;
    int          base;

    rst = 1'b0;
    en_a = 1'b0; run_a = 1'b0; fin_a = 1'b0; fcol_a = 4'd0;
    en_b = 1'b0; run_b = 1'b0; fin_b = 1'b0; fcol_b = 4'd0;
    en_c = 1'b0; run_c = 1'b0; fin_c = 1'b0; fcol_c = 4'd0;
    spawn_exp[0] = 16'h8000; spawn_exp[1] = 16'h4000; spawn_exp[2] = 16'h2000;
    spawn_exp[3] = 16'h1000; spawn_exp[4] = 16'h8800;
    one = 16'h0001;
`ifdef LANE_WRAP_EN
    wrap_exp = 16'h0001;
`else
    wrap_exp = 16'h0000;
`endif

    // Reset values and Run without Enable.
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, "reset1");
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, "reset2");
    for (int i = 0; i < 10; i++)
      step(0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, "run_no_en");

    // Spawn sequence: five ticks, fourth one blocked by the spawn gap.
    base = moved_cnt_a;
    for (int k = 0; k < 5; k++) begin
      step(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, spawn_exp[k], 1'b1, 1'b0, "spawn_tick");
      for (int j = 0; j < 3; j++)
        step(0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, spawn_exp[k], 1'b0, 1'b0, "spawn_hold");
    end
    checks++;
    assert (moved_cnt_a - base == 5) else begin
      errors++;
      $error("FAIL spawn_pulses: observed %0d expected 5", moved_cnt_a - base);
    end

    // Collision beats Enable; lane then frozen in HIT until reset.
    step(0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd11, 16'h8800, 1'b0, 1'b1, "coll");
    for (int i = 0; i < 20; i++)
      step(0, 1'b0, (i % 2 == 0), 1'b1, 1'b1, 4'd11, 16'h8800, 1'b0, 1'b1, "hit_frozen");
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, "hit_reset");

    // Continuous Enable with Run toggled: no shift on the exit or re-entry cycle.
    base = moved_cnt_a;
    step(0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, "frz_enter");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h8000, 1'b1, 1'b0, "frz_run1");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h4000, 1'b1, 1'b0, "frz_run1");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h2000, 1'b1, 1'b0, "frz_run1");
    for (int i = 0; i < 3; i++)
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h2000, 1'b0, 1'b0, "frz_stop");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h2000, 1'b0, 1'b0, "frz_reenter");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h1000, 1'b1, 1'b0, "frz_run2");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h8800, 1'b1, 1'b0, "frz_run2");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h4400, 1'b1, 1'b0, "frz_run2");
    step(0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h4400, 1'b0, 1'b0, "frz_done");
    checks++;
    assert (moved_cnt_a - base == 6) else begin
      errors++;
      $error("FAIL frz_pulses: observed %0d expected 6", moved_cnt_a - base);
    end

    // 12-cell lane: out-of-range and absent frog never hit.
    step(1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, "b_enter");
    step(1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0800, 1'b1, 1'b0, "b_spawn");
    step(1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 16'h0800, 1'b0, 1'b0, "b_col13");
    step(1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd12, 16'h0800, 1'b0, 1'b0, "b_col12");
    step(1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd11, 16'h0800, 1'b0, 1'b0, "b_absent");
    step(1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd11, 16'h0800, 1'b0, 1'b1, "b_col11");

    // Direction 1: preload one car, then 16 ticks with Enable held high.
    step(2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, "c_enter");
    step(2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, "c_tick_nospawn");
    step(2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0001, 1'b1, 1'b0, "c_preload");
    for (int k = 1; k < 16; k++)
      step(2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, one << k, 1'b1, 1'b0, "c_travel");
    step(2, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, wrap_exp, 1'b1, 1'b0, "c_exit");
    step(2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, wrap_exp, 1'b0, 1'b0, "c_idle");
    step(2, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, "c_midreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
